// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: state encoding, branch-target table
// and the HALT instruction encoding.
package fetch_unit_pkg;

  localparam int PC_W_DEF      = 10;
  localparam int LUT_IDX_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  // Branch-target table indexed by the low instruction bits.
  localparam logic [PC_W_DEF-1:0] BR_TARGETS [2**LUT_IDX_W_DEF] = '{
    10'd0,   10'd8,   10'd16,  10'd40,
    10'd64,  10'd100, 10'd128, 10'd200,
    10'd256, 10'd300, 10'd384, 10'd512,
    10'd640, 10'd768, 10'd900, 10'd1020
  };

  localparam logic [15:0] HALT_INSTR = 16'hF000;

endpackage

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch-target lookup: maps the instruction's LUT index to a
// program-counter target from the shared table.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic [LUT_IDX_W-1:0] lut_idx,
  output logic [PC_W-1:0]      target
);

  always_comb begin
    target = PC_W'(BR_TARGETS[lut_idx]);
  end

endmodule

// File: rtl/fetch_unit.sv
// Program counter / fetch sequencer: IDLE -> RUN on Start, branches via branch_lut,
// halts on HALT or ROM end. Optional RUN-cycle counter under FETCH_CYCLE_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int LUT_IDX_W = LUT_IDX_W_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 Branch_en,
  input  logic [LUT_IDX_W-1:0] Lut_idx,
  input  logic                 Halt,
  output logic [PC_W-1:0]      ProgCtr,
  output logic                 Done,
  output logic                 Overflow
`ifdef FETCH_CYCLE_COUNT_EN
  ,
  output logic [15:0]          Cycle_cnt
`endif
);

  fetch_state_t    state, state_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] br_target;
  logic            done_nxt;
  logic            ovf_nxt;

  branch_lut #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) u_branch_lut (
    .lut_idx (Lut_idx),
    .target  (br_target)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      ProgCtr  <= '0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      state    <= state_nxt;
      ProgCtr  <= pc_nxt;
      Done     <= done_nxt;
      Overflow <= ovf_nxt;
    end
  end

  // Within RUN the priority is Start > Halt > Branch > ROM-end > increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = ProgCtr;
    done_nxt  = Done;
    ovf_nxt   = Overflow;
    case (state)
      IDLE, HALTED: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = '0;
          done_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
        end
      end
      RUN: begin
        if (Start) begin
          pc_nxt   = '0;
          done_nxt = 1'b0;
          ovf_nxt  = 1'b0;
        end else if (Halt) begin
          state_nxt = HALTED;
          done_nxt  = 1'b1;
        end else if (Branch_en) begin
          pc_nxt = br_target;
        end else if (&ProgCtr) begin
          // No wrap: running off the ROM end is a halt with Overflow flagged.
          state_nxt = HALTED;
          done_nxt  = 1'b1;
          ovf_nxt   = 1'b1;
        end else begin
          pc_nxt = ProgCtr + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef FETCH_CYCLE_COUNT_EN
  // Counts every edge that begins in RUN; Start clears it, HALTED freezes it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Cycle_cnt <= '0;
    end else if (Start) begin
      Cycle_cnt <= '0;
    end else if ((state == RUN) && (Cycle_cnt != 16'hFFFF)) begin
      Cycle_cnt <= Cycle_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of expected PC/Done/Overflow per edge,
// with asynchronous-reset and ROM-end boundary cases.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PC_W      = 10;
  localparam int LUT_IDX_W = 4;

  typedef struct {
    int   pc;
    logic done;
    logic ovf;
  } exp_t;

  logic                 Clk;
  logic                 Reset_n;
  logic                 Start;
  logic                 Branch_en;
  logic [LUT_IDX_W-1:0] Lut_idx;
  logic                 Halt;
  logic [PC_W-1:0]      ProgCtr;
  logic                 Done;
  logic                 Overflow;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0]          Cycle_cnt;
`endif

  exp_t sb[$];
  int   vectors;
  int   miscompares;

  fetch_unit #(
    .PC_W      (PC_W),
    .LUT_IDX_W (LUT_IDX_W)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Branch_en (Branch_en),
    .Lut_idx   (Lut_idx),
    .Halt      (Halt),
    .ProgCtr   (ProgCtr),
    .Done      (Done),
    .Overflow  (Overflow)
`ifdef FETCH_CYCLE_COUNT_EN
    ,
    .Cycle_cnt (Cycle_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge: drive inputs at negedge, queue the expectation, compare after posedge.
  task automatic step(input string tag, input logic s, input logic b,
                      input logic [LUT_IDX_W-1:0] idx, input logic h,
                      input int epc, input logic ed, input logic eo);
    exp_t e;
    @(negedge Clk);
    Start     = s;
    Branch_en = b;
    Lut_idx   = idx;
    Halt      = h;
    sb.push_back('{pc: epc, done: ed, ovf: eo});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"},   int'(ProgCtr),  e.pc);
    chk({tag, ".done"}, int'(Done),     int'(e.done));
    chk({tag, ".ovf"},  int'(Overflow), int'(e.ovf));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset_n     = 1'b0;
    Start       = 1'b0;
    Branch_en   = 1'b0;
    Lut_idx     = '0;
    Halt        = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset.pc",   int'(ProgCtr),  0);
    chk("reset.done", int'(Done),     0);
    chk("reset.ovf",  int'(Overflow), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Idle ignores branch/halt
    step("idle_ignore", 0, 1, 4'd3, 1, 0, 0, 0);

    // Start then straight-line fetch
    step("start", 1, 0, 4'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 5; i++) step("seq", 0, 0, 4'd0, 0, i, 0, 0);

    // Branch through LUT entry 3
    step("br3", 0, 1, 4'd3, 0, 40, 0, 0);
    step("br3_next", 0, 0, 4'd0, 0, 41, 0, 0);

    // Halt beats branch; HALTED ignores inputs; Start restarts
    step("halt_br", 0, 1, 4'd15, 1, 41, 1, 0);
    step("halted_ignore", 0, 1, 4'd15, 0, 41, 1, 0);
    step("restart", 1, 0, 4'd0, 0, 0, 0, 0);

    // Restart from within RUN
    step("run1", 0, 0, 4'd0, 0, 1, 0, 0);
    step("run_restart", 1, 0, 4'd0, 0, 0, 0, 0);

    // Run to PC=7, then asynchronous reset without a clock edge
    for (int i = 1; i <= 7; i++) step("to7", 0, 0, 4'd0, 0, i, 0, 0);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    chk("async_rst.pc",   int'(ProgCtr),  0);
    chk("async_rst.done", int'(Done),     0);
    chk("async_rst.ovf",  int'(Overflow), 0);
    #2;
    Reset_n = 1'b1;
    step("post_rst_idle", 0, 0, 4'd0, 0, 0, 0, 0);

    // Spin: branch to current PC (entry 0 while at 0)
    step("start2", 1, 0, 4'd0, 0, 0, 0, 0);
    step("spin", 0, 1, 4'd0, 0, 0, 0, 0);

    // ROM end: branch to 1020, run off the end
    step("br15", 0, 1, 4'd15, 0, 1020, 0, 0);
    step("end1", 0, 0, 4'd0, 0, 1021, 0, 0);
    step("end2", 0, 0, 4'd0, 0, 1022, 0, 0);
    step("end3", 0, 0, 4'd0, 0, 1023, 0, 0);
    step("ovf", 0, 0, 4'd0, 0, 1023, 1, 1);
    step("ovf_hold", 0, 1, 4'd3, 0, 1023, 1, 1);
    step("ovf_clear", 1, 0, 4'd0, 0, 0, 0, 0);

`ifdef FETCH_CYCLE_COUNT_EN
    // Start, 8 fetch edges, halt on the 9th RUN edge
    step("cnt_start", 1, 0, 4'd0, 0, 0, 0, 0);
    chk("cnt_cleared", int'(Cycle_cnt), 0);
    for (int i = 1; i <= 8; i++) step("cnt_run", 0, 0, 4'd0, 0, i, 0, 0);
    step("cnt_halt", 0, 0, 4'd0, 1, 8, 1, 0);
    chk("cnt_at_halt", int'(Cycle_cnt), 9);
    step("cnt_frozen", 0, 0, 4'd0, 0, 8, 1, 0);
    chk("cnt_frozen", int'(Cycle_cnt), 9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
